// File: rtl/divider_8_bit_sequential_if.sv
// Start/Done handshake and operand/result bus for the sequential divider.
interface divider_8_bit_sequential_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  Start_In;
  logic [DATA_WIDTH-1:0] Dividend_In;
  logic [DATA_WIDTH-1:0] Divisor_In;
  logic [DATA_WIDTH-1:0] Quotient_Out;
  logic [DATA_WIDTH-1:0] Remainder_Out;
  logic                  Busy_Out;
  logic                  Done_Out;
  logic                  Div_By_Zero_Out;

  // Requester side: issues operands, observes results.
  modport master (
    output Start_In, Dividend_In, Divisor_In,
    input  Quotient_Out, Remainder_Out, Busy_Out, Done_Out, Div_By_Zero_Out
  );

  // Divider side.
  modport slave (
    input  Start_In, Dividend_In, Divisor_In,
    output Quotient_Out, Remainder_Out, Busy_Out, Done_Out, Div_By_Zero_Out
  );
endinterface

// File: rtl/divider_8_bit_sequential.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB
// first, with a Start/Done handshake. Division by zero finishes immediately
// with quotient all ones and remainder equal to the dividend.
module divider_8_bit_sequential #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                         Clock_In,
  input  logic                         Reset_N_In,
  divider_8_bit_sequential_if.slave    bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [DATA_WIDTH-1:0] dsr_q, dsr_d;     // latched divisor
  logic [DATA_WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [CW-1:0]         cnt_q, cnt_d;     // iterations completed
  logic [DATA_WIDTH-1:0] quo_q, quo_d;     // result registers
  logic [DATA_WIDTH-1:0] remo_q, remo_d;
  logic                  dbz_q, dbz_d;

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   trial;
  logic                  q_bit;

  // One restoring step: shift {rem, dividend} left, try subtracting the divisor.
  always_comb begin
    shifted = {rem_q, dvd_q[DATA_WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};
    q_bit   = ~trial[DATA_WIDTH];
  end

  // Next-state and datapath updates for IDLE/CALC/DONE.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.Start_In) begin
          dvd_d = bus.Dividend_In;
          dsr_d = bus.Divisor_In;
          rem_d = '0;
          cnt_d = '0;
          if (bus.Divisor_In == '0) begin
            quo_d   = '1;
            remo_d  = bus.Dividend_In;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        // A negative trial restores: the shifted remainder is kept as-is.
        rem_d = q_bit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
        dvd_d = {dvd_q[DATA_WIDTH-2:0], q_bit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          quo_d   = dvd_d;
          remo_d  = rem_d;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset discards any operation in flight.
  always_ff @(posedge Clock_In) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!Reset_N_In) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.Quotient_Out    = quo_q;
  assign bus.Remainder_Out   = remo_q;
  assign bus.Div_By_Zero_Out = dbz_q;
  assign bus.Busy_Out        = (state_q == CALC);
  assign bus.Done_Out        = (state_q == DONE);

endmodule

// File: tb/tb_divider_8_bit_sequential.sv
// Self-checking bench for the sequential divider: vector table, hand-written
// handshake/reset sequences, and a randomized sweep against plain / and %.
module tb_divider_8_bit_sequential;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   done_total;

  divider_8_bit_sequential_if #(.DATA_WIDTH(8)) dif ();

  divider_8_bit_sequential #(.DATA_WIDTH(8)) dut (
    .Clock_In   (clk),
    .Reset_N_In (rst_n),
    .bus        (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every Done pulse, sampled away from the active edge.
  always @(negedge clk) if (dif.Done_Out === 1'b1) done_total++;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
    int         busy;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; holds Start for exactly one rising edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    dif.Start_In    = 1'b1;
    dif.Dividend_In = a;
    dif.Divisor_In  = b;
    @(negedge clk);
    dif.Start_In = 1'b0;
  endtask

  // Starting in cycle 1 after the accepting edge, count Busy cycles until Done.
  // Returns at the negedge of the Done cycle; lat = 0 means no Done seen.
  task automatic wait_done(output int lat, output int busy);
    lat  = 0;
    busy = 0;
    for (int c = 1; c <= 20; c++) begin
      if (dif.Busy_Out === 1'b1) busy++;
      if (dif.Done_Out === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_results(input string tag, input logic [7:0] q, input logic [7:0] r,
                               input logic dbz);
    check({tag, "_q"},   32'(dif.Quotient_Out),    32'(q));
    check({tag, "_r"},   32'(dif.Remainder_Out),   32'(r));
    check({tag, "_dbz"}, 32'(dif.Div_By_Zero_Out), 32'(dbz));
  endtask

  initial begin
    int lat, busy, d0;
    logic [7:0] a, b;
    logic [7:0] q_exp, r_exp;

    checks      = 0;
    errors      = 0;
    done_total  = 0;
    rst_n       = 1'b0;
    dif.Start_In    = 1'b0;
    dif.Dividend_In = '0;
    dif.Divisor_In  = '0;

    vecs[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 9, 8};
    vecs[1]  = '{8'd5,   8'd10,  8'd0,   8'd5,  1'b0, 9, 8};
    vecs[2]  = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 9, 8};
    vecs[3]  = '{8'd77,  8'd0,   8'd255, 8'd77, 1'b1, 1, 0};
    vecs[4]  = '{8'd9,   8'd3,   8'd3,   8'd0,  1'b0, 9, 8};
    vecs[5]  = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9, 8};
    vecs[6]  = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9, 8};
    vecs[7]  = '{8'd13,  8'd1,   8'd13,  8'd0,  1'b0, 9, 8};
    vecs[8]  = '{8'd0,   8'd0,   8'd255, 8'd0,  1'b1, 1, 0};
    vecs[9]  = '{8'd128, 8'd16,  8'd8,   8'd0,  1'b0, 9, 8};
    vecs[10] = '{8'd254, 8'd17,  8'd14,  8'd16, 1'b0, 9, 8};

    // Reset state.
    repeat (3) @(negedge clk);
    check_results("reset", 8'd0, 8'd0, 1'b0);
    check("reset_busy", 32'(dif.Busy_Out), 32'd0);
    check("reset_done", 32'(dif.Done_Out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors: latency, Busy length, results, and hold in IDLE.
    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(lat, busy);
      check($sformatf("v%0d_lat", i),  32'(lat),  32'(vecs[i].lat));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check_results($sformatf("v%0d", i), vecs[i].q, vecs[i].r, vecs[i].dbz);
      repeat (2) @(negedge clk);
      check_results($sformatf("v%0d_hold", i), vecs[i].q, vecs[i].r, vecs[i].dbz);
    end

    // Back-to-back: second Start in the first IDLE cycle after Done.
    d0 = done_total;
    start_op(8'd255, 8'd1);
    wait_done(lat, busy);
    check("b2b1_lat", 32'(lat), 32'd9);
    check_results("b2b1", 8'd255, 8'd0, 1'b0);
    @(negedge clk);
    start_op(8'd255, 8'd255);
    wait_done(lat, busy);
    check("b2b2_lat", 32'(lat), 32'd9);
    check_results("b2b2", 8'd1, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("b2b_pulses", 32'(done_total - d0), 32'd2);

    // Start and operand changes during CALC are ignored.
    d0 = done_total;
    start_op(8'd100, 8'd9);
    repeat (2) @(negedge clk);
    start_op(8'd50, 8'd5);
    dif.Dividend_In = 8'd77;
    dif.Divisor_In  = 8'd0;
    wait_done(lat, busy);
    check("calc_start_seen", 32'(lat != 0), 32'd1);
    check_results("calc_start", 8'd11, 8'd1, 1'b0);
    repeat (14) @(negedge clk);
    check("calc_start_pulses", 32'(done_total - d0), 32'd1);

    // Reset mid-CALC: outputs clear, no Done, then a normal run.
    start_op(8'd100, 8'd9);
    repeat (3) @(negedge clk);
    d0 = done_total;
    rst_n = 1'b0;
    @(negedge clk);
    check_results("midrst", 8'd0, 8'd0, 1'b0);
    check("midrst_busy", 32'(dif.Busy_Out), 32'd0);
    check("midrst_done", 32'(dif.Done_Out), 32'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done_total - d0), 32'd0);
    start_op(8'd100, 8'd9);
    wait_done(lat, busy);
    check("after_rst_lat", 32'(lat), 32'd9);
    check_results("after_rst", 8'd11, 8'd1, 1'b0);
    @(negedge clk);

    // Randomized sweep against the arithmetic definition.
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      q_exp = a / b;
      r_exp = a % b;
      start_op(a, b);
      wait_done(lat, busy);
      check("rnd_lat", 32'(lat), 32'd9);
      check("rnd_q", 32'(dif.Quotient_Out), 32'(q_exp));
      check("rnd_r", 32'(dif.Remainder_Out), 32'(r_exp));
      check("rnd_inv", 32'(dif.Quotient_Out) * 32'(b) + 32'(dif.Remainder_Out), 32'(a));
      check("rnd_r_lt_b", 32'(dif.Remainder_Out < b), 32'd1);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
